// File: rtl/ocl_adder_engine_if.sv
// Bus bundle between the OCL AXI-L slave channel logic and the adder engine.
// The master drives write beats, read requests and rready; the slave returns read data and status.
interface ocl_adder_engine_if;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        busy;
  logic [31:0] result_lo;

  modport master (
    output wr_en, wr_addr, wdata, wstrb, rd_req, rd_addr, rready,
    input  rvalid, rdata, rresp, busy, result_lo
  );

  modport slave (
    input  wr_en, wr_addr, wdata, wstrb, rd_req, rd_addr, rready,
    output rvalid, rdata, rresp, busy, result_lo
  );
endinterface

// File: rtl/ocl_adder_engine.sv
// Register-mapped 64-bit sliced carry-chain adder behind the OCL AXI-L slave.
// Define OCL_ADDER_SUB_EN to enable subtraction through CTRL bit2 (STATUS[4] shows it).
module ocl_adder_engine #(
  parameter int unsigned SLICE_W    = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0500,
  parameter logic [31:0] UNIMPL_VAL = 32'hDEAD_BEEF
) (
  input logic               clk_main_a0,
  input logic               rst_main_n,
  ocl_adder_engine_if.slave ocl_io
);
  localparam int unsigned NSLICES = 64 / SLICE_W;
  localparam int unsigned IdxW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSLICES - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [63:0]     opa_q, opa_d, opb_q, opb_d;
  logic [63:0]     wa_q, wa_d, wb_q, wb_d;
  logic [63:0]     shadow_q, shadow_d, res_q, res_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d, cflag_q, cflag_d;
  logic            done_q, done_d, ovr_q, ovr_d;
  logic [7:0]      opcnt_q, opcnt_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            start_sub;
`ifdef OCL_ADDER_SUB_EN
  logic            sub_q, sub_d;
  assign start_sub = ocl_io.wdata[2];
`else
  logic            sub_q;
  assign sub_q     = 1'b0;
  assign start_sub = 1'b0;
`endif

  logic        busy;
  logic [31:0] status;
  logic [31:0] wr_off, rd_off, rd_val;
  logic        wr_hit, ctrl_wr, start_wr, clear_wr;
  logic [SLICE_W:0] sum;

  assign busy   = (state_q == StRun);
  assign status = {16'h0, opcnt_q, 3'b000, sub_q, ovr_q, cflag_q, done_q, busy};

  // Offsets are taken relative to the window base so one compare covers the range check.
  assign wr_off   = ocl_io.wr_addr - BASE_ADDR;
  assign rd_off   = ocl_io.rd_addr - BASE_ADDR;
  assign wr_hit   = ocl_io.wr_en && (wr_off < 32'd32);
  assign ctrl_wr  = wr_hit && (wr_off[4:2] == 3'd4);
  assign clear_wr = ctrl_wr && ocl_io.wdata[1];
  assign start_wr = ctrl_wr && ocl_io.wdata[0] && !ocl_io.wdata[1];

  assign sum = {1'b0, wa_q[SLICE_W-1:0]} + {1'b0, wb_q[SLICE_W-1:0]}
             + {{SLICE_W{1'b0}}, carry_q};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    rd_val = UNIMPL_VAL;
    if (rd_off < 32'd32) begin
      case (rd_off[4:2])
        3'd0: rd_val = opa_q[31:0];
        3'd1: rd_val = opa_q[63:32];
        3'd2: rd_val = opb_q[31:0];
        3'd3: rd_val = opb_q[63:32];
        3'd4: rd_val = 32'h0;
        3'd5: rd_val = status;
        3'd6: rd_val = res_q[31:0];
        3'd7: rd_val = res_q[63:32];
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    shadow_d = shadow_q;
    res_d    = res_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cflag_d  = cflag_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    opcnt_d  = opcnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
`ifdef OCL_ADDER_SUB_EN
    sub_d    = sub_q;
`endif

    if (wr_hit && !busy) begin
      case (wr_off[4:2])
        3'd0:    opa_d[31:0]  = merge(opa_q[31:0],  ocl_io.wdata, ocl_io.wstrb);
        3'd1:    opa_d[63:32] = merge(opa_q[63:32], ocl_io.wdata, ocl_io.wstrb);
        3'd2:    opb_d[31:0]  = merge(opb_q[31:0],  ocl_io.wdata, ocl_io.wstrb);
        3'd3:    opb_d[63:32] = merge(opb_q[63:32], ocl_io.wdata, ocl_io.wstrb);
        default: ;
      endcase
    end

    unique case (state_q)
      StIdle: begin
        if (start_wr) begin
          state_d = StRun;
          wa_d    = opa_q;
          // Subtraction folds into the same chain as A + ~B with carry-in 1.
          wb_d    = opb_q ^ {64{start_sub}};
          carry_d = start_sub;
          idx_d   = '0;
          done_d  = 1'b0;
`ifdef OCL_ADDER_SUB_EN
          sub_d   = start_sub;
`endif
        end
      end
      StRun: begin
        wa_d     = wa_q >> SLICE_W;
        wb_d     = wb_q >> SLICE_W;
        shadow_d = (shadow_q >> SLICE_W) | (64'(sum[SLICE_W-1:0]) << (64 - SLICE_W));
        carry_d  = sum[SLICE_W];
        idx_d    = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          res_d   = shadow_d;
          cflag_d = sum[SLICE_W];
          done_d  = 1'b1;
          opcnt_d = opcnt_q + 8'd1;
        end
        if (start_wr) ovr_d = 1'b1;
      end
    endcase

    if (clear_wr) begin
      state_d = StIdle;
      done_d  = 1'b0;
      cflag_d = 1'b0;
      ovr_d   = 1'b0;
      res_d   = '0;
      opcnt_d = '0;
    end

    if (!rvalid_q) begin
      if (ocl_io.rd_req) begin
        rvalid_d = 1'b1;
        rdata_d  = rd_val;
      end
    end else if (ocl_io.rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state_q  <= StIdle;
      opa_q    <= '0;
      opb_q    <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      shadow_q <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cflag_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      opcnt_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
`ifdef OCL_ADDER_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      shadow_q <= shadow_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cflag_q  <= cflag_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      opcnt_q  <= opcnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
`ifdef OCL_ADDER_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign ocl_io.rvalid    = rvalid_q;
  assign ocl_io.rdata     = rdata_q;
  assign ocl_io.rresp     = 2'b00;
  assign ocl_io.busy      = busy;
  assign ocl_io.result_lo = res_q[31:0];
endmodule

// File: tb/tb_ocl_adder_engine.sv
// Scoreboard bench for ocl_adder_engine: reads push expected data, a monitor checks each
// completed read handshake; timing and boundary behaviour are checked inline.
module tb_ocl_adder_engine;
  localparam logic [31:0] OpaLo = 32'h500, OpaHi = 32'h504, OpbLo = 32'h508, OpbHi = 32'h50C;
  localparam logic [31:0] Ctrl  = 32'h510, Stat  = 32'h514, ResLo = 32'h518, ResHi = 32'h51C;

  logic clk_main_a0;
  logic rst_main_n;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  ocl_adder_engine_if ocl ();

  ocl_adder_engine #(
    .SLICE_W    (16),
    .BASE_ADDR  (32'h0000_0500),
    .UNIMPL_VAL (32'hDEAD_BEEF)
  ) dut (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .ocl_io      (ocl)
  );

  initial clk_main_a0 = 1'b0;
  always #5 clk_main_a0 = ~clk_main_a0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_main_a0);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    ocl.wr_en = 1'b1; ocl.wr_addr = a; ocl.wdata = d; ocl.wstrb = s;
    tick();
    ocl.wr_en = 1'b0;
  endtask

  task automatic wait_rd_done(input string nm);
    int n = 0;
    while (ocl.rvalid && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_rvalid_drop"}, 64'(ocl.rvalid), 64'd0);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    sb.push_back('{name: nm, data: exp});
    ocl.rd_req = 1'b1; ocl.rd_addr = a;
    tick();
    ocl.rd_req = 1'b0;
    check({nm, "_rvalid"}, 64'(ocl.rvalid), 64'd1);
    wait_rd_done(nm);
  endtask

  task automatic wait_idle(input string nm, output int cycles);
    cycles = 0;
    while (ocl.busy && cycles < 100) begin
      tick();
      cycles++;
    end
    check({nm, "_idle"}, 64'(ocl.busy), 64'd0);
  endtask

  // Monitor: each completed read handshake is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_main_a0);
      if (ocl.rvalid && ocl.rready) begin
        if (sb.size() == 0) begin
          check("unexpected_read", 64'(ocl.rdata), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check(e.name, 64'(ocl.rdata), 64'(e.data));
          check({e.name, "_rresp"}, 64'(ocl.rresp), 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_main_n = 1'b0;
    ocl.wr_en = 1'b0; ocl.wr_addr = '0; ocl.wdata = '0; ocl.wstrb = '0;
    ocl.rd_req = 1'b0; ocl.rd_addr = '0; ocl.rready = 1'b1;
    repeat (3) tick();
    check("rst_busy", 64'(ocl.busy), 64'd0);
    check("rst_rvalid", 64'(ocl.rvalid), 64'd0);
    check("rst_rdata", 64'(ocl.rdata), 64'd0);
    check("rst_result_lo", 64'(ocl.result_lo), 64'd0);
    rst_main_n = 1'b1;
    tick();

    // Reset-state reads and out-of-window read
    rd("rst_status", Stat, 32'h0);
    rd("rst_res_lo", ResLo, 32'h0);
    rd("ctrl_reads_zero", Ctrl, 32'h0);
    rd("unimpl", 32'h600, 32'hDEAD_BEEF);

    // Carry across the 32-bit boundary: 0x1_FFFF_FFFF + 1 = 0x2_0000_0000
    wr(OpaLo, 32'hFFFF_FFFF, 4'hF);
    wr(OpaHi, 32'h0000_0001, 4'hF);
    wr(OpbLo, 32'h0000_0001, 4'hF);
    wr(OpbHi, 32'h0000_0000, 4'hF);
    wr(Ctrl, 32'h1, 4'hF);
    n = 0;
    while (ocl.busy && n < 100) begin
      n++;
      tick();
    end
    check("busy_cycles", 64'(n), 64'd4);
    check("t2_result_lo", 64'(ocl.result_lo), 64'd0);
    rd("t2_res_hi", ResHi, 32'h2);
    rd("t2_res_lo", ResLo, 32'h0);
    rd("t2_status", Stat, 32'h0000_0102);

    // All-ones add with a second START mid-run
    wr(OpaLo, 32'hFFFF_FFFF, 4'hF);
    wr(OpaHi, 32'hFFFF_FFFF, 4'hF);
    wr(OpbLo, 32'hFFFF_FFFF, 4'hF);
    wr(OpbHi, 32'hFFFF_FFFF, 4'hF);
    wr(Ctrl, 32'h1, 4'hF);
    rd("t3_res_hi_during_run", ResHi, 32'h2);
    check("t3_busy_mid", 64'(ocl.busy), 64'd1);
    wr(Ctrl, 32'h1, 4'hF);
    wait_idle("t3", n);
    check("t3_result_lo", 64'(ocl.result_lo), 64'hFFFF_FFFE);
    rd("t3_res_lo", ResLo, 32'hFFFF_FFFE);
    rd("t3_res_hi", ResHi, 32'hFFFF_FFFF);
    rd("t3_status", Stat, 32'h0000_020E);

    // Byte strobes and operand write dropped while busy
    wr(OpaLo, 32'h0, 4'hF);
    wr(OpaLo, 32'h1122_3344, 4'b0101);
    rd("t4_strobe", OpaLo, 32'h0022_0044);
    wr(Ctrl, 32'h1, 4'hF);
    wr(OpaLo, 32'hAAAA_AAAA, 4'hF);
    wait_idle("t4", n);
    rd("t4_opa_unchanged", OpaLo, 32'h0022_0044);
    rd("t4_res_lo", ResLo, 32'h0022_0043);
    rd("t4_status", Stat, 32'h0000_030E);

    // CLEAR aborts a run; START+CLEAR together does nothing but clear
    wr(Ctrl, 32'h1, 4'hF);
    tick();
    wr(Ctrl, 32'h2, 4'hF);
    check("clear_abort_busy", 64'(ocl.busy), 64'd0);
    check("clear_result_lo", 64'(ocl.result_lo), 64'd0);
    rd("clear_status", Stat, 32'h0);
    rd("clear_res_hi", ResHi, 32'h0);
    wr(Ctrl, 32'h3, 4'hF);
    check("start_clear_no_run", 64'(ocl.busy), 64'd0);
    rd("start_clear_status", Stat, 32'h0);

    // rready back-pressure: data held stable
    ocl.rready = 1'b0;
    sb.push_back('{name: "hold_read", data: 32'h0022_0044});
    ocl.rd_req = 1'b1; ocl.rd_addr = OpaLo;
    tick();
    ocl.rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_rvalid", 64'(ocl.rvalid), 64'd1);
      check("hold_rdata", 64'(ocl.rdata), 64'h0022_0044);
      tick();
    end
    ocl.rready = 1'b1;
    tick();
    check("hold_release_rvalid", 64'(ocl.rvalid), 64'd0);
    check("hold_release_rdata", 64'(ocl.rdata), 64'd0);

    // Asynchronous reset in the middle of a run
    wr(Ctrl, 32'h1, 4'hF);
    wait_idle("pre_rst", n);
    check("pre_rst_result_lo", 64'(ocl.result_lo), 64'h0022_0043);
    wr(Ctrl, 32'h1, 4'hF);
    tick();
    #1 rst_main_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(ocl.busy), 64'd0);
    check("async_rst_result_lo", 64'(ocl.result_lo), 64'd0);
    tick();
    rst_main_n = 1'b1;
    tick();
    rd("post_rst_status", Stat, 32'h0);
    rd("post_rst_opa_hi", OpaHi, 32'h0);

    // Read and write of the same register in one cycle returns the old value
    sb.push_back('{name: "same_cycle_rd_wr", data: 32'h0});
    ocl.wr_en = 1'b1; ocl.wr_addr = OpaLo; ocl.wdata = 32'h5; ocl.wstrb = 4'hF;
    ocl.rd_req = 1'b1; ocl.rd_addr = OpaLo;
    tick();
    ocl.wr_en = 1'b0; ocl.rd_req = 1'b0;
    wait_rd_done("same_cycle");
    rd("after_same_cycle", OpaLo, 32'h5);

    // CTRL bit2: subtract when the feature is built in, ignored otherwise
    wr(OpbLo, 32'h7, 4'hF);
    wr(Ctrl, 32'h5, 4'hF);
    wait_idle("t6a", n);
`ifdef OCL_ADDER_SUB_EN
    rd("t6a_res_lo", ResLo, 32'hFFFF_FFFE);
    rd("t6a_res_hi", ResHi, 32'hFFFF_FFFF);
    rd("t6a_status", Stat, 32'h0000_0112);
`else
    rd("t6a_res_lo", ResLo, 32'h0000_000C);
    rd("t6a_res_hi", ResHi, 32'h0);
    rd("t6a_status", Stat, 32'h0000_0102);
`endif
    wr(OpaLo, 32'h7, 4'hF);
    wr(OpbLo, 32'h5, 4'hF);
    wr(Ctrl, 32'h5, 4'hF);
    wait_idle("t6b", n);
`ifdef OCL_ADDER_SUB_EN
    rd("t6b_res_lo", ResLo, 32'h2);
    rd("t6b_status", Stat, 32'h0000_0216);
`else
    rd("t6b_res_lo", ResLo, 32'h0000_000C);
    rd("t6b_status", Stat, 32'h0000_0202);
`endif

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
